softmax_result_collector: RTL and testbench

SOFTMAX_RESULT_COLLECTOR -- requirements
Module: softmax_result_collector

---
 rtl/softmax_pkg.sv | 18 +
 rtl/softmax_result_buffer.sv | 42 ++++
 rtl/softmax_result_collector.sv | 158 +++++++++++++++
 tb/tb_softmax_result_collector.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared defaults and the collector state encoding for the softmax result path.
package softmax_pkg;

   localparam int DATA_SIZE      = 32;
   localparam int NUMBER_OF_DATA = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } collector_state_t;

   // Pointer width; a single-entry vector still needs a one-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/softmax_result_buffer.sv
// Result storage: one register per entry, single write port, asynchronous read port.
module softmax_result_buffer #(
   parameter int data_size      = 32,
   parameter int number_of_data = 10,
   parameter int idx_w          = 4
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [idx_w-1:0]     wr_addr,
   input  logic [data_size-1:0] wr_data,
   input  logic [idx_w-1:0]     rd_addr,
   output logic [data_size-1:0] rd_data
);

   logic [data_size-1:0] word_vec [number_of_data];

   genvar gi;
   generate
      for (gi = 0; gi < number_of_data; gi++) begin : g_entry
         logic [data_size-1:0] word_reg;

         always_ff @(posedge clk) begin
            if (wr_en && (wr_addr == idx_w'(gi))) begin
               word_reg <= wr_data;
            end
         end

         assign word_vec[gi] = word_reg;
      end
   endgenerate

   // Compare-based mux keeps out-of-range addresses harmless.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < number_of_data; i++) begin
         if (rd_addr == idx_w'(i)) begin
            rd_data = word_vec[i];
         end
      end
   end

endmodule

// File: rtl/softmax_result_collector.sv
// Collects one softmax vector, then drains it to a ready/valid reader.
// Optional running XOR checksum enabled by SOFTMAX_COLLECTOR_CHECKSUM_EN.
module softmax_result_collector
   import softmax_pkg::*;
#(
   parameter int data_size      = DATA_SIZE,
   parameter int number_of_data = NUMBER_OF_DATA
) (
   input  logic                                   clock_i,
   input  logic                                   reset_i,
   input  logic                                   exp_2_data_valid_i,
   input  logic [data_size-1:0]                   exp_2_data_i,
   input  logic                                   rd_ready_i,
   output logic                                   rd_valid_o,
   output logic [data_size-1:0]                   rd_data_o,
   output logic [idx_width(number_of_data)-1:0]   rd_index_o,
   output logic                                   rd_last_o,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic                                   overflow_o,
   output logic [data_size-1:0]                   checksum_o
);

   localparam int IDX_W = idx_width(number_of_data);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(number_of_data - 1);

   collector_state_t state_reg, state_next;
   logic [IDX_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [IDX_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic             done_reg, done_next;
   logic             overflow_reg, overflow_next;
   logic             wr_en;
   logic [data_size-1:0] buf_rd_data;
   logic             in_drain;

   softmax_result_buffer #(
      .data_size      (data_size),
      .number_of_data (number_of_data),
      .idx_w          (IDX_W)
   ) u_buffer (
      .clk     (clock_i),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_reg),
      .wr_data (exp_2_data_i),
      .rd_addr (rd_ptr_reg),
      .rd_data (buf_rd_data)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_reg    <= ST_IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         done_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         done_reg     <= done_next;
         overflow_reg <= overflow_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      done_next     = 1'b0;
      overflow_next = overflow_reg;
      wr_en         = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (exp_2_data_valid_i) begin
               wr_en = 1'b1;
               if (number_of_data == 1) begin
                  state_next  = ST_DRAIN;
                  rd_ptr_next = '0;
               end else begin
                  wr_ptr_next = IDX_W'(1);
                  state_next  = ST_COLLECT;
               end
            end
         end

         ST_COLLECT: begin
            if (exp_2_data_valid_i) begin
               wr_en = 1'b1;
               if (wr_ptr_reg == LAST_IDX) begin
                  state_next  = ST_DRAIN;
                  wr_ptr_next = '0;
                  rd_ptr_next = '0;
               end else begin
                  wr_ptr_next = wr_ptr_reg + IDX_W'(1);
               end
            end
         end

         ST_DRAIN: begin
            // Buffer is full of an unread vector: anything arriving now is lost.
            if (exp_2_data_valid_i) begin
               overflow_next = 1'b1;
            end
            if (rd_ready_i) begin
               if (rd_ptr_reg == LAST_IDX) begin
                  state_next  = ST_IDLE;
                  rd_ptr_next = '0;
                  done_next   = 1'b1;
               end else begin
                  rd_ptr_next = rd_ptr_reg + IDX_W'(1);
               end
            end
         end

         default: begin
            state_next  = ST_IDLE;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
         end
      endcase
   end

   assign in_drain   = (state_reg == ST_DRAIN);
   assign rd_valid_o = in_drain;
   assign rd_data_o  = in_drain ? buf_rd_data : '0;
   assign rd_index_o = in_drain ? rd_ptr_reg : '0;
   assign rd_last_o  = in_drain && (rd_ptr_reg == LAST_IDX);
   assign busy_o     = (state_reg != ST_IDLE);
   assign done_o     = done_reg;
   assign overflow_o = overflow_reg;

`ifdef SOFTMAX_COLLECTOR_CHECKSUM_EN
   logic [data_size-1:0] checksum_reg, checksum_next;

   // The first word of a vector restarts the checksum; it then holds until the next vector.
   always_comb begin
      checksum_next = checksum_reg;
      if (wr_en) begin
         checksum_next = (state_reg == ST_IDLE) ? exp_2_data_i
                                                : (checksum_reg ^ exp_2_data_i);
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         checksum_reg <= '0;
      end else begin
         checksum_reg <= checksum_next;
      end
   end

   assign checksum_o = checksum_reg;
`else
   assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_softmax_result_collector.sv
// Scoreboard bench for softmax_result_collector: queue-based vector model, per-cycle output checks.
module tb_softmax_result_collector;

   localparam int DW = 32;
   localparam int N  = 10;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          valid_i;
   logic [DW-1:0] data_i;
   logic          ready_i;
   logic          rd_valid_o;
   logic [DW-1:0] rd_data_o;
   logic [IW-1:0] rd_index_o;
   logic          rd_last_o;
   logic          busy_o;
   logic          done_o;
   logic          overflow_o;
   logic [DW-1:0] checksum_o;

   softmax_result_collector #(
      .data_size      (DW),
      .number_of_data (N)
   ) dut (
      .clock_i            (clk),
      .reset_i            (reset_i),
      .exp_2_data_valid_i (valid_i),
      .exp_2_data_i       (data_i),
      .rd_ready_i         (ready_i),
      .rd_valid_o         (rd_valid_o),
      .rd_data_o          (rd_data_o),
      .rd_index_o         (rd_index_o),
      .rd_last_o          (rd_last_o),
      .busy_o             (busy_o),
      .done_o             (done_o),
      .overflow_o         (overflow_o),
      .checksum_o         (checksum_o)
   );

   always #5 clk = ~clk;

   // Reference model: words gathered so far, and the vector awaiting readout.
   logic [DW-1:0] pend_q[$];
   logic [DW-1:0] exp_q[$];
   bit            draining = 0;
   bit            ovf_exp  = 0;
   bit            done_exp = 0;
   logic [DW-1:0] cs_exp   = '0;
   logic [DW-1:0] vec [N];

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Monitor + predictor, sampled on the falling edge.
   always @(negedge clk) begin
      bit was_draining;
      check("rd_valid", rd_valid_o, draining);
      check("busy", busy_o, draining || (pend_q.size() != 0));
      check("done", done_o, done_exp);
      check("overflow", overflow_o, ovf_exp);
      if (draining) begin
         check("rd_data", rd_data_o, exp_q[0]);
         check("rd_index", rd_index_o, N - exp_q.size());
         check("rd_last", rd_last_o, exp_q.size() == 1);
`ifdef SOFTMAX_COLLECTOR_CHECKSUM_EN
         check("checksum", checksum_o, cs_exp);
`endif
      end else begin
         check("idle_rd_outputs", {rd_data_o, rd_index_o, rd_last_o}, '0);
      end
`ifndef SOFTMAX_COLLECTOR_CHECKSUM_EN
      check("checksum_zero", checksum_o, '0);
`endif

      done_exp = 0;
      if (reset_i) begin
         pend_q.delete();
         exp_q.delete();
         draining = 0;
         ovf_exp  = 0;
         cs_exp   = '0;
      end else begin
         was_draining = draining;
         if (draining && ready_i) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               draining = 0;
               done_exp = 1;
            end
         end
         if (valid_i) begin
            if (was_draining) begin
               ovf_exp = 1;
            end else begin
               pend_q.push_back(data_i);
               if (pend_q.size() == N) begin
                  exp_q  = pend_q;
                  cs_exp = '0;
                  foreach (pend_q[k]) cs_exp ^= pend_q[k];
                  pend_q.delete();
                  draining = 1;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_vec(input int gmin, input int gmax);
      for (int i = 0; i < N; i++) begin
         valid_i = 1'b1;
         data_i  = vec[i];
         step();
         valid_i = 1'b0;
         if (gmax > 0) begin
            repeat ($urandom_range(gmax, gmin)) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_o || done_o) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) begin
         checks++;
         $display("FAIL wait_idle: got busy=%0b expected 0 within 300 cycles", busy_o);
      end
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1;
      valid_i = 1'b0;
      data_i  = '0;
      ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_i = 1'b0;

      // Back-to-back vector, reader always ready
      ready_i = 1'b1;
      for (int i = 0; i < N; i++) vec[i] = 32'h3C000001 + i;
      send_vec(0, 0);
      wait_idle();

      // Gapped writes with reader toggling every cycle
      ready_i = 1'b0;
      fork
         send_vec(1, 3);
         repeat (80) begin
            step();
            ready_i = ~ready_i;
         end
      join
      ready_i = 1'b1;
      wait_idle();

      // Word arriving during drain is dropped and flags overflow
      ready_i = 1'b0;
      send_vec(0, 0);
      valid_i = 1'b1;
      data_i  = 32'hDEADBEEF;
      step();
      valid_i = 1'b0;
      repeat (3) step();
      ready_i = 1'b1;
      wait_idle();

      // Reset mid-collect; word presented during reset is ignored
      for (int i = 0; i < 5; i++) begin
         valid_i = 1'b1;
         data_i  = 32'h11110000 + i;
         step();
      end
      reset_i = 1'b1;
      data_i  = 32'hBADBAD00;
      step();
      reset_i = 1'b0;
      valid_i = 1'b0;
      for (int i = 0; i < N; i++) vec[i] = 32'h3F000000 + i;
      send_vec(0, 0);
      wait_idle();

      // One-hot words: XOR of the vector is 0x3FF
      for (int i = 0; i < N; i++) vec[i] = 32'h1 << i;
      send_vec(0, 0);
      wait_idle();

      // Valid held continuously: covers input coinciding with the final read
      valid_i = 1'b1;
      for (int i = 0; i < 25; i++) begin
         data_i = $urandom;
         step();
      end
      valid_i = 1'b0;

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         valid_i = ($urandom_range(9, 0) < 6);
         data_i  = $urandom;
         ready_i = $urandom_range(1, 0);
         step();
      end
      valid_i = 1'b0;

      // Flush any partial vector so the collector returns to idle
      ready_i = 1'b1;
      for (int i = 0; i < 40 && rd_valid_o; i++) step();
      for (int i = 0; i < N && pend_q.size() != 0; i++) begin
         valid_i = 1'b1;
         data_i  = $urandom;
         step();
         valid_i = 1'b0;
      end
      wait_idle();

      repeat (3) step();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
